// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser (SYNC, LEN, payload, CSUM framing).
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LEN  = 2'd1,
        ST_PAY  = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic logic len_valid(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle counter: cleared by a byte, runs while enabled, flags expiry on the TIMEOUT_CYC-th idle cycle.
module uart_frame_timeout #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd1740
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [15:0] idle_cnt_r;

    // Idle cycle counter, held at zero outside a frame and saturating at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_r <= 16'd0;
        end else if (clear || !enable) begin
            idle_cnt_r <= 16'd0;
        end else if (idle_cnt_r != TIMEOUT_CYC) begin
            idle_cnt_r <= idle_cnt_r + 16'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // A byte in the same cycle clears the counter and therefore masks expiry
    assign expire = enable && !clear && (idle_cnt_r == (TIMEOUT_CYC - 16'd1));

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: strips SYNC/LEN/CSUM, streams payload, reports frame status.
// Optional inter-byte timeout is enabled with the UART_FRAME_TIMEOUT_EN macro.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 32,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1740
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_dv_in,
    input  logic [7:0] rx_in,
    output logic [7:0] byte_out,
    output logic       byte_dv_out,
    output logic       byte_last_out,
    output logic       frame_ok_out,
    output logic       frame_err_out,
    output logic [1:0] err_code_out
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_r, next_state_s;
    logic [7:0] len_r, len_s;
    logic [7:0] cnt_r, cnt_s;
    logic [7:0] sum_r, sum_s;
    logic [7:0] csum_s;
    logic [7:0] byte_s;
    logic       dv_s, last_s, ok_s, err_s;
    logic [1:0] code_s;

`ifdef UART_FRAME_TIMEOUT_EN
    logic timeout_s;

    uart_frame_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_dv_in),
        .enable (state_r != ST_HUNT),
        .expire (timeout_s)
    );
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYC;
`endif

    assign csum_s = sum_r + rx_in;

    // Next-state, datapath and registered-output decode
    always_comb begin
        next_state_s = state_r;
        len_s        = len_r;
        cnt_s        = cnt_r;
        sum_s        = sum_r;
        byte_s       = byte_out;
        dv_s         = 1'b0;
        last_s       = 1'b0;
        ok_s         = 1'b0;
        err_s        = 1'b0;
        code_s       = err_code_out;
        if (rx_dv_in) begin
            case (state_r)
                ST_HUNT: begin
                    if (rx_in == SYNC_BYTE) begin
                        next_state_s = ST_LEN;
                    end else begin
                        next_state_s = ST_HUNT;
                    end
                end
                ST_LEN: begin
                    if (len_valid(rx_in, MAX_LEN_B)) begin
                        len_s        = rx_in;
                        sum_s        = rx_in;
                        cnt_s        = 8'd0;
                        next_state_s = ST_PAY;
                    end else begin
                        err_s        = 1'b1;
                        code_s       = ERR_LEN;
                        next_state_s = ST_HUNT;
                    end
                end
                ST_PAY: begin
                    sum_s  = sum_r + rx_in;
                    byte_s = rx_in;
                    dv_s   = 1'b1;
                    cnt_s  = cnt_r + 8'd1;
                    if (cnt_s == len_r) begin
                        last_s       = 1'b1;
                        next_state_s = ST_CSUM;
                    end else begin
                        next_state_s = ST_PAY;
                    end
                end
                ST_CSUM: begin
                    if (csum_s == 8'd0) begin
                        ok_s   = 1'b1;
                        code_s = ERR_NONE;
                    end else begin
                        err_s  = 1'b1;
                        code_s = ERR_CSUM;
                    end
                    next_state_s = ST_HUNT;
                end
                default: begin
                    next_state_s = ST_HUNT;
                end
            endcase
        end
`ifdef UART_FRAME_TIMEOUT_EN
        else if (timeout_s) begin
            err_s        = 1'b1;
            code_s       = ERR_TIMEOUT;
            next_state_s = ST_HUNT;
        end
`endif
        else begin
            next_state_s = state_r;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_HUNT;
            len_r         <= 8'd0;
            cnt_r         <= 8'd0;
            sum_r         <= 8'd0;
            byte_out      <= 8'd0;
            byte_dv_out   <= 1'b0;
            byte_last_out <= 1'b0;
            frame_ok_out  <= 1'b0;
            frame_err_out <= 1'b0;
            err_code_out  <= ERR_NONE;
        end else begin
            state_r       <= next_state_s;
            len_r         <= len_s;
            cnt_r         <= cnt_s;
            sum_r         <= sum_s;
            byte_out      <= byte_s;
            byte_dv_out   <= dv_s;
            byte_last_out <= last_s;
            frame_ok_out  <= ok_s;
            frame_err_out <= err_s;
            err_code_out  <= code_s;
        end
    end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter MAX_LEN, default 32, is the largest legal payload length in bytes, range 1..255.
REQ-002 Parameter TIMEOUT_CYC, default 1740, is the inter-byte timeout in clk cycles (20 bit-times at 87 clk/bit), 16-bit.
REQ-003 clk  input  1  is the single clock; all logic is on posedge clk.
REQ-004 rst  input  1  is a synchronous, active-high reset.
REQ-005 rx_dv_in  input  1  is a one-cycle strobe from the UART receiver marking a valid byte on rx_in.
REQ-006 rx_in  input  8  is the received byte, valid only when rx_dv_in=1.
REQ-007 byte_out  output  8  is the payload byte.
REQ-008 byte_dv_out  output  1  is a one-cycle strobe qualifying byte_out.
REQ-009 byte_last_out  output  1  is high with byte_dv_out on the final payload byte of a frame.
REQ-010 frame_ok_out  output  1  is a one-cycle pulse indicating a frame completed with a correct checksum.
REQ-011 frame_err_out  output  1  is a one-cycle pulse indicating a frame was aborted.
REQ-012 err_code_out  output  2  gives the abort cause, held until the next frame_ok_out or frame_err_out: 1=checksum, 2=bad length, 3=timeout.

Function
REQ-013 Frame format SHALL be: SYNC 0xA5, LEN, LEN payload bytes, CSUM.
REQ-014 The state machine SHALL have states HUNT, LEN, PAY, CSUM; reset state is HUNT.
REQ-015 HUNT: a byte equal to 0xA5 SHALL go to LEN; any other byte SHALL be discarded and the state SHALL stay HUNT.
REQ-016 LEN: a value of 0 or greater than MAX_LEN SHALL pulse frame_err_out with err_code_out=2 and return to HUNT; otherwise the block SHALL store the length, seed the 8-bit sum with LEN, and go to PAY.
REQ-017 PAY: each byte SHALL be added to the sum modulo 256 and emitted on byte_out with byte_dv_out exactly 1 cycle after its rx_dv_in; the LEN-th byte SHALL assert byte_last_out and go to CSUM.
REQ-018 CSUM: if (sum + CSUM) mod 256 == 0, frame_ok_out SHALL pulse; otherwise frame_err_out SHALL pulse with err_code_out=1. In both cases the next state is HUNT.
REQ-019 frame_ok_out and frame_err_out SHALL each assert 1 cycle after the deciding rx_dv_in, never together.
REQ-020 Payload bytes are streamed, not buffered; the consumer SHALL discard the frame when frame_err_out pulses.
REQ-021 A byte 0xA5 inside LEN, PAY or CSUM SHALL be treated as data, not as a resync.
REQ-022 The payload counter SHALL be 8 bits and SHALL not wrap, because LEN is bounded by MAX_LEN.

Reset
REQ-023 rst SHALL force state HUNT, clear the counters and sum, and set all outputs to 0, including err_code_out=0.
REQ-024 rst asserted mid-frame SHALL abandon the frame without pulsing frame_err_out.

Configuration
REQ-025 With UART_FRAME_TIMEOUT_EN defined, the idle counter SHALL clear on every rx_dv_in and increment otherwise while the state is not HUNT.
REQ-026 With UART_FRAME_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYC SHALL pulse frame_err_out with err_code_out=3 and return to HUNT.
REQ-027 With UART_FRAME_TIMEOUT_EN defined, if rx_dv_in and the timeout occur in the same cycle, the byte SHALL win and the timeout SHALL be suppressed.
REQ-028 With UART_FRAME_TIMEOUT_EN undefined, no counter SHALL be instantiated, code 3 SHALL never occur, and the parser SHALL wait indefinitely.

Structure
REQ-029 Package uart_frame_pkg SHALL hold the state enum, SYNC_BYTE=8'hA5, and the ERR_CSUM, ERR_LEN and ERR_TIMEOUT codes.
REQ-030 Sub-module uart_frame_timeout SHALL implement the idle counter (clear, enable, expire) and SHALL be instantiated only under UART_FRAME_TIMEOUT_EN.

Verification
REQ-031 Good frame: A5 02 10 20 CE -> byte_out 10 then 20, last on 20, frame_ok_out pulse, no err.
REQ-032 Bad checksum: A5 02 10 20 CF -> both bytes emitted, frame_err_out, err_code_out=1.
REQ-033 Bad length: A5 00, then A5 21 with MAX_LEN=32 -> two frame_err_out pulses with code 2 and no byte_dv_out; garbage 55 A5 01 7F 80 -> 55 ignored, byte 7F emitted, frame_ok_out.
REQ-034 Timeout (macro on, TIMEOUT_CYC=100): A5 03 01 then silence -> frame_err_out code 3 at 100 cycles after the last strobe; a byte arriving exactly on cycle 100 -> no error.
REQ-035 Reset mid-payload: A5 04 01 02, rst 1 cycle, then A5 01 05 FA -> no err pulse, outputs 0 during reset, second frame OK.
REQ-036 Embedded sync: A5 02 A5 A5 B4 -> payload A5 A5 emitted, frame_ok_out.
